autoscale_restore: RTL

- Inverse of the input autoscaler in the CORDIC atan/magnitude datapath.
- Queues each sample's applied left-shift and, when the corresponding downstream result (e.g. CORDIC magnitude) emerges, right-shifts that result by the same amount to restore the original scale.
- Decouples the arbitrary CORDIC latency from the autoscaler through an in-order shift-tag FIFO.

---
 rtl/autoscale_pkg.sv | 21 ++
 rtl/shift_tag_fifo.sv | 71 +++++++
 rtl/autoscale_restore.sv | 111 +++++++++++
 3 files changed

// File: rtl/autoscale_pkg.sv
// Shared definitions for the CORDIC input autoscaler and its inverse
// (autoscale_restore): shift-width derivation, restore latency and the
// shift-tag type carried between them.
package autoscale_pkg;

    // Cycles from din_valid to dout_valid in autoscale_restore.
    localparam int RESTORE_LATENCY = 2;

    // Data width the autoscaler normalises; sets the default tag width.
    localparam int AUTOSCALE_DATA_WIDTH = 32;

    // Bits needed to encode any left-shift of a data_width-bit word.
    function automatic int shift_width_for(input int data_width);
        return (data_width > 1) ? $clog2(data_width) : 1;
    endfunction

    localparam int SHIFT_TAG_WIDTH = shift_width_for(AUTOSCALE_DATA_WIDTH);

    typedef logic [SHIFT_TAG_WIDTH-1:0] shift_tag_t;

endpackage

// File: rtl/shift_tag_fifo.sv
// In-order FIFO of autoscaler shift tags. A push is refused while the FIFO
// is full, and a pop is refused while it is empty. Each refusal sets a
// sticky flag that only reset clears. There is no bypass path: a pop on an
// empty FIFO never sees a push made in the same cycle.
module shift_tag_fifo #(
    parameter  int WIDTH = 5,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count,
    output logic             overflow,
    output logic             underflow
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Tag storage; contents are meaningless while count is zero, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (push && full) begin
                overflow <= 1'b1;
            end
            if (pop && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/autoscale_restore.sv
// Undoes the CORDIC input autoscaler. Each shift applied by the autoscaler
// is queued as a tag. When the matching downstream result arrives, it is
// shifted right by that same amount. The latency from din_valid to
// dout_valid is fixed at two cycles.
// Build option AUTOSCALE_RESTORE_ROUND_EN selects round-half-up. When it is
// not defined, the shift truncates.
module autoscale_restore
    import autoscale_pkg::*;
#(
    parameter  int DIN_WIDTH   = 32,
    parameter  int SHIFT_WIDTH = shift_width_for(DIN_WIDTH),
    parameter  int FIFO_DEPTH  = 16,
    localparam int CW          = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [SHIFT_WIDTH-1:0] shift_in,
    input  logic                   shift_valid,
    input  logic [DIN_WIDTH-1:0]   din,
    input  logic                   din_valid,
    output logic [DIN_WIDTH-1:0]   dout,
    output logic                   dout_valid,
    output logic [CW-1:0]          tag_count,
    output logic                   overflow,
    output logic                   underflow
);

    logic [SHIFT_WIDTH-1:0] fifo_data;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [SHIFT_WIDTH-1:0] pop_tag;

    logic                   s1_valid;
    logic [DIN_WIDTH-1:0]   s1_din;
    logic [SHIFT_WIDTH-1:0] s1_shift;
    logic [DIN_WIDTH-1:0]   shifted;
`ifdef AUTOSCALE_RESTORE_ROUND_EN
    logic [DIN_WIDTH:0]     round_sum;
`endif

    shift_tag_fifo #(
        .WIDTH (SHIFT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (shift_valid),
        .push_data (shift_in),
        .pop       (din_valid),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (tag_count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    // An underflowing sample still goes through, with no shift applied.
    assign pop_tag = fifo_empty ? '0 : fifo_data;

    // Stage 1: capture the sample together with the tag it pops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_din   <= '0;
            s1_shift <= '0;
        end else begin
            s1_valid <= din_valid;
            if (din_valid) begin
                s1_din   <= din;
                s1_shift <= pop_tag;
            end
        end
    end

    // Descale shifter. With rounding, half an LSB of the result is added
    // at DIN_WIDTH+1 bits before the shift, so the sum cannot wrap.
    always_comb begin
        shifted = '0;
`ifdef AUTOSCALE_RESTORE_ROUND_EN
        round_sum = '0;
`endif
        if (int'(s1_shift) > DIN_WIDTH - 1) begin
            shifted = '0;
        end else if (s1_shift == '0) begin
            shifted = s1_din;
        end else begin
`ifdef AUTOSCALE_RESTORE_ROUND_EN
            round_sum = {1'b0, s1_din}
                      + ((DIN_WIDTH+1)'(1) << (s1_shift - SHIFT_WIDTH'(1)));
            shifted   = DIN_WIDTH'(round_sum >> s1_shift);
`else
            shifted   = s1_din >> s1_shift;
`endif
        end
    end

    // Stage 2: register the result. dout holds its value between samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= s1_valid;
            if (s1_valid) begin
                dout <= shifted;
            end
        end
    end

endmodule
